// File: rtl/dlx_decode_stage.sv
// DLX instruction-decode stage: combinational decode into a single registered bundle
// with valid/ready on both sides, flush, illegal flagging and load-use stalling.
module dlx_decode_stage #(
    parameter  int unsigned XLEN     = 32,
    parameter  int unsigned NREG     = 32,
    parameter  int unsigned LOAD_LAT = 1,
    parameter  int unsigned LINK_REG = 31,
    localparam int unsigned REG_W    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_op,
    output logic [REG_W-1:0] rs1,
    output logic [REG_W-1:0] rs2,
    output logic [REG_W-1:0] rd,
    output logic [XLEN-1:0]  imm,
    output logic             use_imm,
    output logic             is_load,
    output logic             is_store,
    output logic             is_branch,
    output logic             is_jump,
    output logic             link,
    output logic             illegal
);

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,  ALU_ADD = 4'd1,  ALU_SUB = 4'd2,  ALU_AND = 4'd3,
        ALU_OR   = 4'd4,  ALU_XOR = 4'd5,  ALU_SLL = 4'd6,  ALU_SRL = 4'd7,
        ALU_SEQ  = 4'd10, ALU_SLE = 4'd11, ALU_SLT = 4'd12, ALU_SNE = 4'd13,
        ALU_SRA  = 4'd14, ALU_LINK = 4'd15
    } alu_e;

    typedef struct packed {
        alu_e             alu_op;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  imm;
        logic             use_imm;
        logic             is_load;
        logic             is_store;
        logic             is_branch;
        logic             is_jump;
        logic             link;
        logic             illegal;
    } bundle_t;

    bundle_t          dec;
    bundle_t          bundle_q;
    logic             valid_q;
    logic             hazard;
    logic             accept;
    logic [5:0]       opcode;
    logic [LOAD_LAT-1:0] sb_v_q;
    logic [REG_W-1:0] sb_rd_q [LOAD_LAT];

    assign opcode = in_instr[31:26];

    always_comb begin
        dec = '0;
        case (opcode)
            6'h00: begin
                dec.rs1 = REG_W'(in_instr[25:21]);
                dec.rs2 = REG_W'(in_instr[20:16]);
                dec.rd  = REG_W'(in_instr[15:11]);
                case (in_instr[5:0])
                    6'h20:   dec.alu_op = ALU_ADD;
                    6'h22:   dec.alu_op = ALU_SUB;
                    6'h24:   dec.alu_op = ALU_AND;
                    6'h25:   dec.alu_op = ALU_OR;
                    6'h26:   dec.alu_op = ALU_XOR;
                    6'h04:   dec.alu_op = ALU_SLL;
                    6'h06:   dec.alu_op = ALU_SRL;
                    6'h28:   dec.alu_op = ALU_SEQ;
                    6'h2c:   dec.alu_op = ALU_SLE;
                    6'h2a:   dec.alu_op = ALU_SLT;
                    6'h29:   dec.alu_op = ALU_SNE;
                    6'h07:   dec.alu_op = ALU_SRA;
                    default: begin
                        dec.illegal = 1'b1;
                        dec.rd      = '0;
                    end
                endcase
            end
            6'h02, 6'h03: begin
                dec.is_jump = 1'b1;
                dec.imm     = XLEN'($signed(in_instr[25:0]));
                if (opcode[0]) begin
                    dec.link   = 1'b1;
                    dec.alu_op = ALU_LINK;
                    dec.rd     = REG_W'(LINK_REG);
                end
            end
            default: begin
                // I-type common fields first; individual opcodes override below
                dec.rs1     = REG_W'(in_instr[25:21]);
                dec.rd      = REG_W'(in_instr[20:16]);
                dec.use_imm = 1'b1;
                dec.imm     = XLEN'($signed(in_instr[15:0]));
                case (opcode)
                    6'h08: dec.alu_op = ALU_ADD;
                    6'h0a: dec.alu_op = ALU_SUB;
                    6'h0c: begin dec.alu_op = ALU_AND; dec.imm = XLEN'(in_instr[15:0]); end
                    6'h0d: begin dec.alu_op = ALU_OR;  dec.imm = XLEN'(in_instr[15:0]); end
                    6'h0e: begin dec.alu_op = ALU_XOR; dec.imm = XLEN'(in_instr[15:0]); end
                    6'h0f: begin
                        dec.alu_op = ALU_OR;
                        dec.rs1    = '0;
                        dec.imm    = XLEN'({in_instr[15:0], 16'h0000});
                    end
                    6'h23: begin dec.alu_op = ALU_ADD; dec.is_load = 1'b1; end
                    6'h2b: begin
                        dec.alu_op   = ALU_ADD;
                        dec.is_store = 1'b1;
                        dec.rs2      = REG_W'(in_instr[20:16]);
                        dec.rd       = '0;
                    end
                    6'h04: begin dec.alu_op = ALU_SEQ; dec.is_branch = 1'b1; dec.rd = '0; end
                    6'h05: begin dec.alu_op = ALU_SNE; dec.is_branch = 1'b1; dec.rd = '0; end
                    6'h12: begin dec.is_jump = 1'b1; dec.rd = '0; dec.imm = '0; end
                    6'h13: begin
                        dec.is_jump = 1'b1;
                        dec.link    = 1'b1;
                        dec.alu_op  = ALU_LINK;
                        dec.rd      = REG_W'(LINK_REG);
                        dec.imm     = '0;
                    end
                    default: begin
                        dec         = '0;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Unused source fields decode to 0, so r0 never matches a pending load.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < LOAD_LAT; i++) begin
            if (sb_v_q[i] && (((dec.rs1 != '0) && (dec.rs1 == sb_rd_q[i])) ||
                              ((dec.rs2 != '0) && (dec.rs2 == sb_rd_q[i]))))
                hazard = 1'b1;
        end
        hazard = hazard & in_valid;
    end

    assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (flush) begin
            valid_q  <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            bundle_q <= dec;
        end else if (out_ready) begin
            valid_q  <= 1'b0;
        end
    end

    // Scoreboard shifts unconditionally; flush leaves it intact since issued loads still land.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sb_v_q <= '0;
            for (int unsigned i = 0; i < LOAD_LAT; i++) sb_rd_q[i] <= '0;
        end else begin
            sb_v_q[0]  <= accept && dec.is_load && (dec.rd != '0);
            sb_rd_q[0] <= (accept && dec.is_load) ? dec.rd : '0;
            for (int unsigned i = 1; i < LOAD_LAT; i++) begin
                sb_v_q[i]  <= sb_v_q[i-1];
                sb_rd_q[i] <= sb_rd_q[i-1];
            end
        end
    end

    assign out_valid = valid_q;
    assign alu_op    = bundle_q.alu_op;
    assign rs1       = bundle_q.rs1;
    assign rs2       = bundle_q.rs2;
    assign rd        = bundle_q.rd;
    assign imm       = bundle_q.imm;
    assign use_imm   = bundle_q.use_imm;
    assign is_load   = bundle_q.is_load;
    assign is_store  = bundle_q.is_store;
    assign is_branch = bundle_q.is_branch;
    assign is_jump   = bundle_q.is_jump;
    assign link      = bundle_q.link;
    assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_dlx_decode_stage.sv
// Directed bench for dlx_decode_stage: decode vectors, handshake, load-use stall, flush.
module tb_dlx_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [3:0]  alu_op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        use_imm, is_load, is_store, is_branch, is_jump, link, illegal;

    logic        in_valid2, in_ready2, flush2, out_valid2, out_ready2;
    logic [31:0] in_instr2;
    logic [3:0]  alu_op2;
    logic [4:0]  rs1_2, rs2_2, rd2;
    logic [31:0] imm2;
    logic        use_imm2, is_load2, is_store2, is_branch2, is_jump2, link2, illegal2;

    int n_tests = 0;
    int n_fail  = 0;
    int stalls;

    localparam logic [31:0] LW_R6 = 32'h8C260008;

    always #5 clk = ~clk;

    dlx_decode_stage #(.XLEN(32), .NREG(32), .LOAD_LAT(1), .LINK_REG(31)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .use_imm(use_imm),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_jump(is_jump),
        .link(link), .illegal(illegal)
    );

    // Longer load latency so a load entry outlives a flush cycle.
    dlx_decode_stage #(.XLEN(32), .NREG(32), .LOAD_LAT(3), .LINK_REG(31)) u_dut_lat3 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_instr(in_instr2), .flush(flush2), .out_valid(out_valid2), .out_ready(out_ready2),
        .alu_op(alu_op2), .rs1(rs1_2), .rs2(rs2_2), .rd(rd2), .imm(imm2), .use_imm(use_imm2),
        .is_load(is_load2), .is_store(is_store2), .is_branch(is_branch2), .is_jump(is_jump2),
        .link(link2), .illegal(illegal2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_add(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        return {6'h00, s1, s2, d, 5'h00, 6'h20};
    endfunction

    // Offer instr until accepted (bounded); returns number of stalled cycles.
    task automatic send(input logic [31:0] instr, output int n_stall);
        n_stall  = 0;
        in_valid = 1'b1;
        in_instr = instr;
        #1;
        while (!in_ready && n_stall < 20) begin
            @(posedge clk); #1;
            n_stall++;
        end
        if (!in_ready) check("send_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b1; in_instr = mk_add(5'd3, 5'd1, 5'd2);
        flush = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_instr2 = '0; flush2 = 1'b0; out_ready2 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_rd", rd, 0);
        check("rst_imm", imm, 0);
        check("rst_is_jump", is_jump, 0);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("add_valid", out_valid, 1);
        check("add_alu", alu_op, 1);
        check("add_rs1", rs1, 1);
        check("add_rs2", rs2, 2);
        check("add_rd", rd, 3);
        check("add_use_imm", use_imm, 0);

        send(32'h2085FFFF, stalls);
        check("addi_imm", imm, 32'hFFFFFFFF);
        check("addi_rd", rd, 5);
        check("addi_rs1", rs1, 4);
        check("addi_use_imm", use_imm, 1);

        send(32'h30228000, stalls);
        check("andi_imm", imm, 32'h00008000);
        check("andi_alu", alu_op, 3);
        check("andi_rd", rd, 2);

        send(32'h3C001234, stalls);
        check("lhi_imm", imm, 32'h12340000);
        check("lhi_alu", alu_op, 4);
        check("lhi_rs1", rs1, 0);

        send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3F}, stalls);
        check("rbad_illegal", illegal, 1);
        check("rbad_rd", rd, 0);
        check("rbad_alu", alu_op, 0);

        send(32'h0C000100, stalls);
        check("jal_jump", is_jump, 1);
        check("jal_link", link, 1);
        check("jal_alu", alu_op, 15);
        check("jal_rd", rd, 31);
        check("jal_imm", imm, 32'h100);
        check("jal_illegal", illegal, 0);

        send(32'hFC000000, stalls);
        check("op3f_illegal", illegal, 1);
        check("op3f_rd", rd, 0);
        check("op3f_jump", is_jump, 0);

        // load-use
        send(LW_R6, stalls);
        check("lw_stalls", stalls, 0);
        check("lw_is_load", is_load, 1);
        check("lw_rd", rd, 6);
        send(mk_add(5'd7, 5'd6, 5'd6), stalls);
        check("lu_stalls", stalls, 1);
        check("lu_rd", rd, 7);
        check("lu_is_load", is_load, 0);
        send(LW_R6, stalls);
        send(mk_add(5'd3, 5'd1, 5'd2), stalls);
        check("indep_stalls", stalls, 0);
        send(mk_add(5'd7, 5'd6, 5'd6), stalls);
        check("dep_late_stalls", stalls, 0);

        // back-pressure
        @(posedge clk); #1;
        check("bp_drain", out_valid, 0);
        out_ready = 1'b0;
        send(mk_add(5'd1, 5'd1, 5'd2), stalls);
        check("bp_first_rd", rd, 1);
        in_valid = 1'b1;
        in_instr = mk_add(5'd2, 5'd1, 5'd2);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_hold_rd", rd, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel_ready", in_ready, 1);
        @(posedge clk); #1;
        check("bp_seq2_valid", out_valid, 1);
        check("bp_seq2_rd", rd, 2);
        in_instr = mk_add(5'd3, 5'd1, 5'd2);
        @(posedge clk); #1;
        check("bp_seq3_rd", rd, 3);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_end_valid", out_valid, 0);

        // flush while stalled by the consumer
        out_ready = 1'b0;
        send(mk_add(5'd4, 5'd1, 5'd2), stalls);
        check("fl_valid_before", out_valid, 1);
        flush = 1'b1; in_valid = 1'b1; in_instr = mk_add(5'd5, 5'd1, 5'd2);
        #1;
        check("fl_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("fl_valid_after", out_valid, 0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

        // flush keeps the pending load entry (LOAD_LAT=3 instance)
        in_valid2 = 1'b1; in_instr2 = LW_R6;
        #1;
        check("l3_lw_ready", in_ready2, 1);
        @(posedge clk); #1;
        check("l3_lw_is_load", is_load2, 1);
        flush2 = 1'b1; in_instr2 = mk_add(5'd7, 5'd6, 5'd6);
        #1;
        check("l3_fl_ready", in_ready2, 0);
        @(posedge clk); #1;
        check("l3_fl_valid", out_valid2, 0);
        flush2 = 1'b0;
        #1;
        check("l3_haz1", in_ready2, 0);
        @(posedge clk); #1;
        check("l3_haz2", in_ready2, 0);
        @(posedge clk); #1;
        check("l3_clear", in_ready2, 1);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        check("l3_dep_valid", out_valid2, 1);
        check("l3_dep_rd", rd2, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
